// File: rtl/bitdepth_pkg.sv
// Shared constants and helpers for the bitdepth_reduce block.
// Holds the rounding-site names, the dither LFSR constants and the
// width/saturation helper functions used by the top and channel modules.
package bitdepth_pkg;

  localparam string MODE_RIGHT = "RIGHT";
  localparam string MODE_LEFT  = "LEFT";

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Number of bits dropped per channel
  function automatic int calc_d(input int in_bits, input int out_bits);
    return in_bits - out_bits;
  endfunction

  // Saturation flag for one channel, evaluated on the stage-1 value.
  // RIGHT: the rounding add carried into bit IN.
  // LEFT : any bit above the kept LSBs is set.
  function automatic logic sat_flag(input logic        is_right,
                                    input logic [63:0] s1_val,
                                    input int          in_bits,
                                    input int          out_bits);
    if (is_right)
      return ((s1_val >> in_bits) & 64'd1) != 64'd0;
    return (s1_val >> out_bits) != 64'd0;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bitdepth_reduce_ch.sv
// One channel of the width reducer across both pipeline stages.
// Stage 1 registers the input plus its rounding offset on IN+1 bits so the
// carry out is kept; stage 2 registers the reduced sample and its saturation
// flag. The rounding offset is chosen by the parent (zero for LEFT mode).
module bitdepth_reduce_ch
  import bitdepth_pkg::*;
#(
  parameter int    C_IN_BIT_NUM  = 10,
  parameter int    C_OUT_BIT_NUM = 8,
  parameter string C_CHANGE_SITE = "RIGHT",
  parameter int    C_RND_BIT_NUM = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s1_load,
  input  logic                     s2_load,
  input  logic [C_IN_BIT_NUM-1:0]  in_sample,
  input  logic [C_RND_BIT_NUM-1:0] rnd,
  output logic [C_OUT_BIT_NUM-1:0] out_sample,
  output logic                     sat
);

  localparam int D       = calc_d(C_IN_BIT_NUM, C_OUT_BIT_NUM);
  localparam bit IS_LEFT = (C_CHANGE_SITE == MODE_LEFT);

  logic [C_IN_BIT_NUM:0]    s1_sum;
  logic [C_IN_BIT_NUM:0]    s1_sum_d;
  logic [C_OUT_BIT_NUM-1:0] out_d;
  logic                     sat_d;

  // Stage-1 input: sample widened by one bit plus the rounding offset
  always_comb begin
    s1_sum_d = {1'b0, in_sample} + (C_IN_BIT_NUM + 1)'(rnd);
  end

  // Stage-2 input: reduced sample, forced to all ones on saturation
  always_comb begin
    sat_d = sat_flag(!IS_LEFT, 64'(s1_sum), C_IN_BIT_NUM, C_OUT_BIT_NUM);
    out_d = '1;
    if (!sat_d) begin
      if (IS_LEFT)
        out_d = s1_sum[C_OUT_BIT_NUM-1:0];
      else
        out_d = s1_sum[C_IN_BIT_NUM-1:D];
    end
  end

  // Stage-1 register, loads on an accepted input beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      s1_sum <= '0;
    else if (s1_load)
      s1_sum <= s1_sum_d;
  end

  // Stage-2 register, holds while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sample <= '0;
      sat        <= 1'b0;
    end else if (s2_load) begin
      out_sample <= out_d;
      sat        <= sat_d;
    end
  end

endmodule

// File: rtl/bitdepth_reduce.sv
// Streaming sample-width reducer: C_CH_NUM channels of C_IN_BIT_NUM bits
// to C_OUT_BIT_NUM bits through a 2-stage valid/ready pipeline, with a
// saturating debug counter of saturated channel samples.
// Optional build macro BITDEPTH_REDUCE_DITHER_EN replaces the fixed
// half-LSB rounding offset (RIGHT mode) with bits of a 16-bit LFSR that
// advances once per accepted beat. Dither bit selection assumes D <= 16.
module bitdepth_reduce
  import bitdepth_pkg::*;
#(
  parameter int    C_IN_BIT_NUM  = 10,
  parameter int    C_OUT_BIT_NUM = 8,
  parameter int    C_CH_NUM      = 3,
  parameter string C_CHANGE_SITE = "RIGHT",
  parameter int    C_CNT_BIT_NUM = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [C_CH_NUM*C_IN_BIT_NUM-1:0]  s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic [C_CH_NUM*C_OUT_BIT_NUM-1:0] m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [C_CNT_BIT_NUM-1:0]          sat_cnt,
  input  logic                              sat_clr
);

  localparam int D        = calc_d(C_IN_BIT_NUM, C_OUT_BIT_NUM);
  localparam int RND_W    = (D > 0) ? D : 1;
  localparam bit IS_RIGHT = (C_CHANGE_SITE == MODE_RIGHT);
  localparam int INC_W    = $clog2(C_CH_NUM + 1);

  logic                   s1_valid;
  logic                   s2_valid;
  logic                   s2_can_load;
  logic                   s1_load;
  logic                   s2_load;
  logic [C_CH_NUM-1:0]    sat_vec;
  logic [INC_W-1:0]       sat_inc;
  logic [C_CNT_BIT_NUM:0] cnt_sum;

  // Handshake: stage 2 frees when empty or draining; s_ready follows m_ready
  always_comb begin
    s2_can_load = !s2_valid || m_ready;
    s_ready     = !s1_valid || s2_can_load;
    s1_load     = s_valid && s_ready;
    s2_load     = s1_valid && s2_can_load;
    m_valid     = s2_valid;
  end

  // Pipeline occupancy flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load)
        s1_valid <= 1'b1;
      else if (s2_load)
        s1_valid <= 1'b0;

      if (s2_load)
        s2_valid <= 1'b1;
      else if (m_ready)
        s2_valid <= 1'b0;
    end
  end

`ifdef BITDEPTH_REDUCE_DITHER_EN
  logic [15:0] lfsr;
  logic [31:0] lfsr_dup;

  // Dither source, stepped once per accepted input beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= LFSR_SEED;
    else if (s1_load)
      lfsr <= lfsr_next(lfsr);
  end

  // Doubled copy lets a channel's bit window wrap past bit 15
  always_comb begin
    lfsr_dup = {lfsr, lfsr};
  end
`endif

  for (genvar c = 0; c < C_CH_NUM; c++) begin : g_ch
    logic [RND_W-1:0] rnd_c;

    if (IS_RIGHT && (D > 0)) begin : g_rnd
`ifdef BITDEPTH_REDUCE_DITHER_EN
      assign rnd_c = RND_W'(lfsr_dup >> ((c * D) % 16));
`else
      assign rnd_c = RND_W'(1) << (D - 1);
`endif
    end else begin : g_no_rnd
      assign rnd_c = '0;
    end

    bitdepth_reduce_ch #(
      .C_IN_BIT_NUM  (C_IN_BIT_NUM),
      .C_OUT_BIT_NUM (C_OUT_BIT_NUM),
      .C_CHANGE_SITE (C_CHANGE_SITE),
      .C_RND_BIT_NUM (RND_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .s1_load    (s1_load),
      .s2_load    (s2_load),
      .in_sample  (s_data[c*C_IN_BIT_NUM +: C_IN_BIT_NUM]),
      .rnd        (rnd_c),
      .out_sample (m_data[c*C_OUT_BIT_NUM +: C_OUT_BIT_NUM]),
      .sat        (sat_vec[c])
    );
  end

  // Count saturated channels in the beat currently in stage 2
  always_comb begin
    sat_inc = '0;
    for (int c = 0; c < C_CH_NUM; c++)
      sat_inc = sat_inc + INC_W'(sat_vec[c]);
    cnt_sum = {1'b0, sat_cnt} + (C_CNT_BIT_NUM + 1)'(sat_inc);
  end

  // Saturation counter: clear wins, counts on output transfer, sticks at max
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (sat_clr)
      sat_cnt <= '0;
    else if (s2_valid && m_ready)
      sat_cnt <= cnt_sum[C_CNT_BIT_NUM] ? '1 : cnt_sum[C_CNT_BIT_NUM-1:0];
  end

endmodule

// File: tb/tb_bitdepth_reduce.sv
// Bench for bitdepth_reduce: a RIGHT 10->8 single-channel instance with a
// 4-bit counter and a LEFT 10->8 three-channel instance.
module tb_bitdepth_reduce;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [9:0]  r_s_data;
  logic        r_s_valid, r_s_ready;
  logic [7:0]  r_m_data;
  logic        r_m_valid, r_m_ready;
  logic [3:0]  r_sat_cnt;
  logic        r_sat_clr;

  logic [29:0] l_s_data;
  logic        l_s_valid, l_s_ready;
  logic [23:0] l_m_data;
  logic        l_m_valid, l_m_ready;
  logic [15:0] l_sat_cnt;
  logic        l_sat_clr;

  bitdepth_reduce #(
    .C_IN_BIT_NUM(10), .C_OUT_BIT_NUM(8), .C_CH_NUM(1),
    .C_CHANGE_SITE("RIGHT"), .C_CNT_BIT_NUM(4)
  ) dut_r (
    .clk(clk), .rst_n(rst_n),
    .s_data(r_s_data), .s_valid(r_s_valid), .s_ready(r_s_ready),
    .m_data(r_m_data), .m_valid(r_m_valid), .m_ready(r_m_ready),
    .sat_cnt(r_sat_cnt), .sat_clr(r_sat_clr)
  );

  bitdepth_reduce #(
    .C_IN_BIT_NUM(10), .C_OUT_BIT_NUM(8), .C_CH_NUM(3),
    .C_CHANGE_SITE("LEFT"), .C_CNT_BIT_NUM(16)
  ) dut_l (
    .clk(clk), .rst_n(rst_n),
    .s_data(l_s_data), .s_valid(l_s_valid), .s_ready(l_s_ready),
    .m_data(l_m_data), .m_valid(l_m_valid), .m_ready(l_m_ready),
    .sat_cnt(l_sat_cnt), .sat_clr(l_sat_clr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef BITDEPTH_REDUCE_DITHER_EN
  logic [15:0] lfsr_m;
  task automatic lfsr_seed();
    lfsr_m = 16'hACE1;
  endtask
  task automatic lfsr_step();
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  endtask
  function automatic logic [1:0] r_round();
    return lfsr_m[1:0];
  endfunction
`else
  task automatic lfsr_seed();
  endtask
  task automatic lfsr_step();
  endtask
  function automatic logic [1:0] r_round();
    return 2'd2;
  endfunction
`endif

  // Expected {sat, out} for one RIGHT-mode sample
  function automatic logic [8:0] r_model(input logic [9:0] din);
    logic [10:0] sum;
    sum = {1'b0, din} + {9'd0, r_round()};
    return sum[10] ? 9'h1FF : {1'b0, sum[9:2]};
  endfunction

  logic [8:0] exp_q[$];
  int         r_rx;
  logic       r_hold_chk;
  logic [7:0] r_hold;
  logic [3:0] sat_model;
  logic       r_seen_block;

  // One clock cycle on the RIGHT instance with scoreboard checks
  task automatic r_cycle(input logic v, input logic [9:0] d, input logic rdy,
                         input logic clr, output logic acc, output logic mv);
    logic [8:0] e;
    @(negedge clk);
    r_s_valid = v;
    r_s_data  = d;
    r_m_ready = rdy;
    r_sat_clr = clr;
    #1;
    check("sat_cnt", 32'(r_sat_cnt), 32'(sat_model));
    if (r_hold_chk) begin
      check("hold_valid", 32'(r_m_valid), 1);
      check("hold_data", 32'(r_m_data), 32'(r_hold));
    end
    mv  = r_m_valid;
    acc = v & r_s_ready;
    if (v && !r_s_ready) r_seen_block = 1'b1;
    if (r_m_valid && rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_out: got %0h expected none", r_m_data);
      end else begin
        e = exp_q.pop_front();
        check("m_data", 32'(r_m_data), 32'(e[7:0]));
        r_rx++;
        if (e[8] && !clr) sat_model = (sat_model == 4'hF) ? 4'hF : sat_model + 4'd1;
      end
    end
    if (clr) sat_model = 4'd0;
    if (acc) begin
      exp_q.push_back(r_model(d));
      lfsr_step();
    end
    r_hold_chk = r_m_valid & !rdy;
    r_hold     = r_m_data;
  endtask

  typedef struct {
    logic [9:0] din;
    logic [7:0] dout;
    int         nsat;
  } rvec_t;

  typedef struct {
    logic [29:0] din;
    logic [23:0] dout;
    int          nsat;
  } lvec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rvec_t rtbl[8];
    lvec_t ltbl[4];
    logic  acc, mv;
    int    sent, cyc, tot;

    rtbl[0] = '{10'h005, 8'h01, 0};
    rtbl[1] = '{10'h006, 8'h02, 0};
    rtbl[2] = '{10'h3FE, 8'hFF, 1};
    rtbl[3] = '{10'h3FD, 8'hFF, 0};
    rtbl[4] = '{10'h000, 8'h00, 0};
    rtbl[5] = '{10'h001, 8'h00, 0};
    rtbl[6] = '{10'h002, 8'h01, 0};
    rtbl[7] = '{10'h3FC, 8'hFF, 0};

    ltbl[0] = '{{10'h0FF, 10'h1AB, 10'h0AB}, {8'hFF, 8'hFF, 8'hAB}, 1};
    ltbl[1] = '{{10'h100, 10'h000, 10'h3FF}, {8'hFF, 8'h00, 8'hFF}, 2};
    ltbl[2] = '{{10'h200, 10'h0FF, 10'h055}, {8'hFF, 8'hFF, 8'h55}, 1};
    ltbl[3] = '{{10'h0FF, 10'h000, 10'h080}, {8'hFF, 8'h00, 8'h80}, 0};

    rst_n = 1'b0;
    r_s_data = '0; r_s_valid = 1'b0; r_m_ready = 1'b1; r_sat_clr = 1'b0;
    l_s_data = '0; l_s_valid = 1'b0; l_m_ready = 1'b1; l_sat_clr = 1'b0;
    sat_model = 4'd0; r_hold_chk = 1'b0; r_hold = '0; r_rx = 0; r_seen_block = 1'b0;
    lfsr_seed();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_r_m_valid", 32'(r_m_valid), 0);
    check("rst_r_m_data", 32'(r_m_data), 0);
    check("rst_r_sat_cnt", 32'(r_sat_cnt), 0);
    check("rst_l_m_valid", 32'(l_m_valid), 0);
    check("rst_l_m_data", 32'(l_m_data), 0);
    check("rst_l_sat_cnt", 32'(l_sat_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_r_s_ready", 32'(r_s_ready), 1);
    check("rel_l_s_ready", 32'(l_s_ready), 1);

    // RIGHT rounding table, one beat at a time, 2-cycle latency
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      r_cycle(1'b1, rtbl[i].din, 1'b1, 1'b0, acc, mv);
      check("tbl_accept", 32'(acc), 1);
      r_cycle(1'b0, 10'h0, 1'b1, 1'b0, acc, mv);
      check("tbl_lat1_valid", 32'(mv), 0);
      r_cycle(1'b0, 10'h0, 1'b1, 1'b0, acc, mv);
      check("tbl_lat2_valid", 32'(mv), 1);
`ifndef BITDEPTH_REDUCE_DITHER_EN
      check("tbl_out", 32'(r_m_data), 32'(rtbl[i].dout));
`endif
      tot += rtbl[i].nsat;
    end
    r_cycle(1'b0, 10'h0, 1'b1, 1'b0, acc, mv);
`ifndef BITDEPTH_REDUCE_DITHER_EN
    check("tbl_sat_cnt", 32'(r_sat_cnt), 32'(tot));
`endif

    // LEFT clip table, three channels
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      l_s_valid = 1'b1;
      l_s_data  = ltbl[i].din;
      #1;
      check("l_s_ready", 32'(l_s_ready), 1);
      @(negedge clk);
      l_s_valid = 1'b0;
      #1;
      check("l_lat1_valid", 32'(l_m_valid), 0);
      @(negedge clk);
      #1;
      check("l_lat2_valid", 32'(l_m_valid), 1);
      check("l_out", 32'(l_m_data), 32'(ltbl[i].dout));
      tot += ltbl[i].nsat;
    end
    @(negedge clk);
    #1;
    check("l_sat_cnt", 32'(l_sat_cnt), 32'(tot));

    // Backpressure: 8 incrementing beats, m_ready pattern 1,0,0,1
    sent = 0; cyc = 0; r_rx = 0; r_seen_block = 1'b0;
    while ((r_rx < 8) && (cyc < 200)) begin
      r_cycle(sent < 8, 10'(32'h100 + 4 * sent),
              (cyc % 4 == 0) || (cyc % 4 == 3), 1'b0, acc, mv);
      if (acc) sent++;
      cyc++;
    end
    check("bp_received", 32'(r_rx), 8);
    check("bp_s_ready_low", 32'(r_seen_block), 1);

    // Counter holds at max with a 4-bit counter
    r_cycle(1'b0, 10'h0, 1'b1, 1'b1, acc, mv);
    sent = 0; cyc = 0; r_rx = 0;
    while ((r_rx < 20) && (cyc < 100)) begin
      r_cycle(sent < 20, 10'h3FF, 1'b1, 1'b0, acc, mv);
      if (acc) sent++;
      cyc++;
    end
    check("cnt_received", 32'(r_rx), 20);
    r_cycle(1'b0, 10'h0, 1'b1, 1'b0, acc, mv);
`ifndef BITDEPTH_REDUCE_DITHER_EN
    check("cnt_hold_max", 32'(r_sat_cnt), 32'hF);
`endif

    // Clear on the same cycle as a saturating transfer
    r_cycle(1'b1, 10'h3FF, 1'b1, 1'b0, acc, mv);
    r_cycle(1'b0, 10'h0, 1'b1, 1'b0, acc, mv);
    r_cycle(1'b0, 10'h0, 1'b1, 1'b1, acc, mv);
    check("clr_xfer_valid", 32'(mv), 1);
    r_cycle(1'b0, 10'h0, 1'b1, 1'b0, acc, mv);
    check("clr_priority", 32'(r_sat_cnt), 0);
    for (int k = 0; k < 4; k++)
      r_cycle(k == 0, 10'h3FF, 1'b1, 1'b0, acc, mv);

`ifdef BITDEPTH_REDUCE_DITHER_EN
    // Dither: constant near-full-scale input, count checked per 8-beat window
    for (int k = 0; k < 64; k++) begin
      r_cycle(1'b1, 10'h3FE, 1'b1, k % 8 == 0, acc, mv);
      check("dith_accept", 32'(acc), 1);
      if (mv) check("dith_out", 32'(r_m_data), 32'hFF);
    end
    for (int k = 0; k < 3; k++) begin
      r_cycle(1'b0, 10'h0, 1'b1, 1'b0, acc, mv);
      if (mv) check("dith_out", 32'(r_m_data), 32'hFF);
    end
`endif

    // Reset with both stages full
    r_cycle(1'b1, 10'h3FF, 1'b0, 1'b0, acc, mv);
    check("fill_acc0", 32'(acc), 1);
    r_cycle(1'b1, 10'h3FE, 1'b0, 1'b0, acc, mv);
    check("fill_acc1", 32'(acc), 1);
    r_cycle(1'b1, 10'h3FD, 1'b0, 1'b0, acc, mv);
    check("full_s_ready", 32'(acc), 0);
    @(negedge clk);
    r_s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 32'(r_m_valid), 0);
    check("midrst_m_data", 32'(r_m_data), 0);
    check("midrst_sat_cnt", 32'(r_sat_cnt), 0);
    exp_q.delete();
    sat_model = 4'd0;
    r_hold_chk = 1'b0;
    lfsr_seed();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      r_cycle(1'b0, 10'h0, 1'b1, 1'b0, acc, mv);
      check("postrst_no_emit", 32'(mv), 0);
    end
    r_cycle(1'b1, 10'h005, 1'b1, 1'b0, acc, mv);
    r_cycle(1'b0, 10'h0, 1'b1, 1'b0, acc, mv);
    r_cycle(1'b0, 10'h0, 1'b1, 1'b0, acc, mv);
    check("postrst_new_valid", 32'(mv), 1);
`ifndef BITDEPTH_REDUCE_DITHER_EN
    check("postrst_new_data", 32'(r_m_data), 32'h01);
`endif
    r_cycle(1'b0, 10'h0, 1'b1, 1'b0, acc, mv);
    check("drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bitdepth_reduce.md
Name: bitdepth_reduce

Overview:
- Streaming sample-width reducer: converts C_CH_NUM channels of C_IN_BIT_NUM bits to C_OUT_BIT_NUM bits.
- Inverse of the team's width-extend block, used on the output side of the video/data path, e.g. 10-bit internal pixels to 8-bit link.
- Rounds or clips per channel through a 2-stage valid/ready pipeline.
- Counts saturation events for debug.

Parameters:
- C_IN_BIT_NUM, 10: input sample width per channel; must be ≥ C_OUT_BIT_NUM.
- C_OUT_BIT_NUM, 8: output sample width per channel; must be ≥ 2.
- C_CH_NUM, 3: channels per beat.
- C_CHANGE_SITE, "RIGHT": "RIGHT" drops LSBs with rounding; "LEFT" keeps LSBs and clips the MSBs.
- C_CNT_BIT_NUM, 16: saturation counter width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  C_CH_NUM*C_IN_BIT_NUM  packed input; channel 0 at the LSBs.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- m_data  out  C_CH_NUM*C_OUT_BIT_NUM  packed output; channel 0 at the LSBs.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- sat_cnt  out  C_CNT_BIT_NUM  number of channel samples saturated since the last clear.
- sat_clr  in  1  synchronous clear of sat_cnt.

Behaviour:
- Reset: m_valid=0, m_data=0, sat_cnt=0, both pipeline stages empty, s_ready=1 from the first cycle after reset release.
- Handshake:
  - Stage 1 loads when s_valid & s_ready.
  - Stage 2 loads from stage 1 when stage 2 is empty or being drained.
  - s_ready = !stage1_valid | stage2_can_load; this is combinational from m_ready.
  - m_data and m_valid come from stage-2 registers.
  - m_data is held stable while m_valid & !m_ready.
  - No beat may be lost or duplicated.
- Latency: 2 cycles from accepted input to m_valid when m_ready is held 1. Throughput is 1 beat/cycle.
- RIGHT mode, D = IN-OUT:
  - Stage 1 computes sum = in + R on IN+1 bits; R = 1<<(D-1) (round half up).
  - Stage 2 outputs sum[IN-1:D]. If sum[IN]=1, output is all ones and the event counts as saturated.
- LEFT mode: output = in[OUT-1:0] if in[IN-1:OUT]==0; otherwise all ones and the event counts as saturated.
- D==0 (IN==OUT): data passes unchanged with the same 2-cycle latency; never saturates.
- sat_cnt:
  - Incremented in stage 2 by the number of saturated channels in the beat, counted when the beat transfers out (m_valid & m_ready).
  - Holds at all ones (no wrap).
  - sat_clr has priority: clear, and discard that cycle's increment.
- Reset mid-stream: in-flight beats are discarded, nothing is emitted after rst_n rises, and the counter returns to 0.
- Channels are processed independently; there is no cross-channel carry.

Optional Feature:
- Macro: BITDEPTH_REDUCE_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded 16'hACE1 at reset and advances once per accepted input beat.
  - In RIGHT mode with D≥1, R per channel = LFSR bits [c*D +: D], taken modulo 16 bits (wrapping), instead of the fixed half-LSB.
  - Saturation and counting rules are unchanged.
  - LEFT mode is unaffected.
- Undefined: fixed rounding constant; no LFSR logic is present.

Decomposition:
- Package bitdepth_pkg holds:
  - the mode string constants;
  - the LFSR seed and tap constants;
  - a function computing D;
  - a function computing the per-channel saturation flag.
- Natural sub-module bitdepth_reduce_ch: one channel's rounding/clip logic across stage 1 and stage 2, instantiated C_CH_NUM times in a generate loop. Handshake, counter and LFSR stay in the top level.

Test Plan:
- RIGHT, 10→8, C_CH_NUM=1, m_ready=1:
  - inputs 0x005, 0x006, 0x3FE → outputs 0x01, 0x02, 0xFF, each 2 cycles after its accept;
  - sat_cnt=1.
- LEFT, 10→8: inputs 0x0AB, 0x1AB → outputs 0xAB, 0xFF; sat_cnt=1.
- Backpressure: stream 8 incrementing beats while m_ready toggles 1,0,0,1 repeating → all 8 outputs in order, m_data stable while stalled, s_ready=0 when both stages are full.
- Counter:
  - force C_CNT_BIT_NUM=4 and send 20 saturating beats → sat_cnt holds 0xF;
  - pulse sat_clr on the same cycle as a saturating transfer → sat_cnt=0.
- Reset: assert rst_n=0 with 2 beats in flight, then release → m_valid stays 0 until new input; sat_cnt=0.
- Dither (macro defined), RIGHT 10→8: input 0x3FE constant for 64 beats → outputs only 0xFF; the saturation count matches the LFSR-predicted model value.
